// File: rtl/inst_rom_loader.sv
// inst_rom_loader: RV32 instruction memory with a boot-time byte-stream loader.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   w_en_i/w_addr_i/w_data_i   direct word write (byte address), ignored while hold_o
//   r_en_i/r_addr_i            fetch read (byte address), 1-cycle registered result
//   inst_o/inst_valid_o        fetched word and its valid flag (NOP_INST when stalled)
//   hold_o                     core stall while a load session is active
//   load_start_i/load_len_i    start a load of load_len_i words at word 0 (IDLE only)
//   byte_valid_i/byte_data_i/byte_ready_o   little-endian byte stream, valid/ready
//   load_done_o                one-cycle pulse at session end
//   load_err_o                 sticky: last requested length exceeded DEPTH
module inst_rom_loader #(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 4096,
    parameter int unsigned ADDR_BIT = 12,
    parameter int unsigned ADDR_LSB = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en_i,
    input  logic [31:0]         w_addr_i,
    input  logic [DW-1:0]       w_data_i,
    input  logic                r_en_i,
    input  logic [31:0]         r_addr_i,
    output logic [DW-1:0]       inst_o,
    output logic                inst_valid_o,
    output logic                hold_o,
    input  logic                load_start_i,
    input  logic [ADDR_BIT:0]   load_len_i,
    input  logic                byte_valid_i,
    input  logic [7:0]          byte_data_i,
    output logic                byte_ready_o,
    output logic                load_done_o,
    output logic                load_err_o
);

    localparam int unsigned LANES  = DW / 8;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = ADDR_BIT + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [DW-1:0]     NOP_W     = DW'(NOP_INST);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [DW-1:0]      asm_q, asm_d;
    logic               err_q, err_d;
    logic [DW-1:0]      inst_q, inst_d;
    logic               valid_q, valid_d;

    logic [DW-1:0]      mem [DEPTH];

    logic [ADDR_BIT-1:0] w_idx, r_idx;
    logic [IDX_W-1:0]    mem_widx, mem_ridx;
    logic [DW-1:0]       mem_wdata, load_word;
    logic [CNT_W-1:0]    cnt_inc;
    logic                load_we, direct_we, mem_we, holding;

    // Address bits outside the word index are intentionally ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{w_addr_i[31:ADDR_BIT+ADDR_LSB], w_addr_i[ADDR_LSB-1:0],
                                r_addr_i[31:ADDR_BIT+ADDR_LSB], r_addr_i[ADDR_LSB-1:0]};

    assign w_idx   = w_addr_i[ADDR_BIT+ADDR_LSB-1:ADDR_LSB];
    assign r_idx   = r_addr_i[ADDR_BIT+ADDR_LSB-1:ADDR_LSB];
    assign cnt_inc = cnt_q + CNT_ONE;
    assign holding = (state_q != StIdle);

    // Loader FSM, byte assembly and session bookkeeping.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        err_d        = err_q;
        load_we      = 1'b0;
        byte_ready_o = 1'b0;
        load_done_o  = 1'b0;
        // Current partial word with the incoming byte merged into its lane.
        load_word    = asm_q;
        load_word[{lane_q, 3'b000} +: 8] = byte_data_i;

        case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    cnt_d  = '0;
                    lane_d = '0;
                    if (load_len_i > DEPTH_C) begin
                        len_d = DEPTH_C;
                        err_d = 1'b1;
                    end else begin
                        len_d = load_len_i;
                        err_d = 1'b0;
                    end
                    state_d = (load_len_i == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                byte_ready_o = 1'b1;
                if (byte_valid_i) begin
                    if (lane_q == LAST_LANE) begin
                        load_we = 1'b1;
                        cnt_d   = cnt_inc;
                        lane_d  = '0;
                        if (cnt_inc == len_q) begin
                            state_d = StDone;
                        end
                    end else begin
                        asm_d  = load_word;
                        lane_d = lane_q + LANE_ONE;
                    end
                end
            end
            StDone: begin
                load_done_o = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Write port: loader owns memory during a session, direct port only in IDLE.
    always_comb begin
        direct_we = w_en_i && (state_q == StIdle);
        mem_we    = (direct_we || load_we) && !rst;
        mem_widx  = load_we ? IDX_W'(cnt_q) : IDX_W'(w_idx);
        mem_wdata = load_we ? load_word : w_data_i;
        mem_ridx  = IDX_W'(r_idx);
    end

    // Read port with same-cycle write forwarding.
    always_comb begin
        inst_d  = inst_q;
        valid_d = 1'b0;
        if (r_en_i) begin
            if (holding) begin
                inst_d = NOP_W;
            end else begin
                valid_d = 1'b1;
                inst_d  = (mem_we && (mem_widx == mem_ridx)) ? mem_wdata : mem[mem_ridx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
            inst_q  <= NOP_W;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign hold_o       = holding;
    assign load_err_o   = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: randomized reads/writes/loads against
// a word-array reference model.
module tb_inst_rom_loader;

    localparam int DEPTH    = 4096;
    localparam int HOLD_IDX = 3000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [31:0] w_addr, w_data;
    logic        r_en;
    logic [31:0] r_addr;
    logic [31:0] inst;
    logic        inst_valid, hold, load_start, byte_valid, byte_ready, load_done, load_err;
    logic [12:0] load_len;
    logic [7:0]  byte_data;

    always #5 clk = ~clk;

    inst_rom_loader dut (
        .clk          (clk),
        .rst          (rst),
        .w_en_i       (w_en),
        .w_addr_i     (w_addr),
        .w_data_i     (w_data),
        .r_en_i       (r_en),
        .r_addr_i     (r_addr),
        .inst_o       (inst),
        .inst_valid_o (inst_valid),
        .hold_o       (hold),
        .load_start_i (load_start),
        .load_len_i   (load_len),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .load_done_o  (load_done),
        .load_err_o   (load_err)
    );

    logic [31:0] model_mem [DEPTH];
    int          known_q[$];
    logic [31:0] load_words[$];
    logic        err_exp;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte address for a word index with random wrap-around and byte-offset bits.
    function automatic logic [31:0] make_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[13:2] = idx[11:0];
        return a;
    endfunction

    task automatic note_write(input int idx, input logic [31:0] d);
        model_mem[idx] = d;
        known_q.push_back(idx);
    endtask

    task automatic test_reset();
        rst = 1'b1; w_en = 0; w_addr = 0; w_data = 0; r_en = 0; r_addr = 0;
        load_start = 0; load_len = 0; byte_valid = 0; byte_data = 0;
        step(); step();
        rst = 1'b0;
        n_vec++; if (inst !== NOP) begin n_err++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP); end
        n_vec++; if ({inst_valid, hold, byte_ready, load_done, load_err} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got=%b exp=00000",
                              {inst_valid, hold, byte_ready, load_done, load_err});
        end
        err_exp = 1'b0;
    endtask

    task automatic test_direct_rw();
        logic [31:0] exp_inst, d;
        int idx;
        logic rd;
        w_en = 1; w_addr = 32'h8; w_data = 32'hDEAD_BEEF; step();
        note_write(2, 32'hDEAD_BEEF);
        w_en = 0; r_en = 1; r_addr = 32'h8; step(); r_en = 0;
        n_vec++; if (inst !== 32'hDEAD_BEEF || inst_valid !== 1'b1) begin
            n_err++; $display("FAIL direct_rd got=%h/%b exp=deadbeef/1", inst, inst_valid);
        end
        exp_inst = 32'hDEAD_BEEF;
        for (int i = 0; i < 64; i++) begin
            idx = (i == 0) ? HOLD_IDX : $urandom_range(DEPTH - 1);
            d = $urandom;
            w_en = 1; w_addr = make_addr(idx); w_data = d; step();
            note_write(idx, d);
        end
        w_en = 0;
        // Pipelined reads, one per cycle, with random idle cycles.
        for (int i = 0; i < 200; i++) begin
            rd  = 1'($urandom_range(1));
            idx = known_q[$urandom_range(known_q.size() - 1)];
            r_en = rd; r_addr = make_addr(idx);
            step();
            if (rd) exp_inst = model_mem[idx];
            n_vec++; if (inst !== exp_inst || inst_valid !== rd) begin
                n_err++; $display("FAIL pipe_rd idx=%0d got=%h/%b exp=%h/%b",
                                  idx, inst, inst_valid, exp_inst, rd);
            end
        end
        r_en = 0;
    endtask

    task automatic test_forward();
        logic [31:0] d;
        int idx;
        for (int i = 0; i < 6; i++) begin
            idx = (i == 0) ? 5 : $urandom_range(DEPTH - 1);
            d = $urandom;
            w_en = 1; w_addr = make_addr(idx); w_data = d;
            r_en = 1; r_addr = make_addr(idx);
            step();
            w_en = 0; r_en = 0;
            note_write(idx, d);
            n_vec++; if (inst !== d || inst_valid !== 1'b1) begin
                n_err++; $display("FAIL fwd idx=%0d got=%h/%b exp=%h/1", idx, inst, inst_valid, d);
            end
        end
    endtask

    // One load session of len_req words from load_words, byte_valid every gap cycles.
    task automatic run_load(input int len_req, input int gap);
        int eff, nbytes, bi, cyc, idx;
        logic [31:0] w;
        logic rd, bv;
        eff    = (len_req > DEPTH) ? DEPTH : len_req;
        nbytes = eff * 4;
        err_exp = (len_req > DEPTH);
        load_start = 1; load_len = len_req[12:0]; step(); load_start = 0;
        n_vec++; if (hold !== 1'b1 || load_err !== err_exp) begin
            n_err++; $display("FAIL start hold/err got=%b/%b exp=1/%b", hold, load_err, err_exp);
        end
        bi = 0; cyc = 0;
        while (bi < nbytes && cyc < nbytes * gap + 16) begin
            n_vec++; if ({hold, byte_ready, load_done} !== 3'b110) begin
                n_err++; $display("FAIL load_busy byte=%0d got=%b exp=110",
                                  bi, {hold, byte_ready, load_done});
            end
            bv = ((cyc % gap) == 0);
            w  = load_words[bi / 4];
            byte_valid = bv; byte_data = w[8 * (bi % 4) +: 8];
            rd = 1'($urandom_range(1));
            r_en = rd; r_addr = $urandom;
            w_en = (eff <= HOLD_IDX) ? 1'($urandom_range(1)) : 1'b0;
            w_addr = make_addr(HOLD_IDX); w_data = $urandom;
            step();
            if (bv) bi++;
            cyc++;
            if (rd) begin
                n_vec++; if (inst !== NOP || inst_valid !== 1'b0) begin
                    n_err++; $display("FAIL hold_rd got=%h/%b exp=%h/0", inst, inst_valid, NOP);
                end
            end
        end
        byte_valid = 0; r_en = 0; w_en = 0;
        if (bi < nbytes) begin
            n_vec++; n_err++;
            $display("FAIL load_timeout accepted=%0d required=%0d", bi, nbytes);
        end
        n_vec++; if ({hold, byte_ready, load_done} !== 3'b101) begin
            n_err++; $display("FAIL done_cycle got=%b exp=101", {hold, byte_ready, load_done});
        end
        step();
        n_vec++; if ({hold, byte_ready, load_done, load_err} !== {3'b000, err_exp}) begin
            n_err++; $display("FAIL after_done got=%b exp=%b",
                              {hold, byte_ready, load_done, load_err}, {3'b000, err_exp});
        end
        for (int i = 0; i < eff; i++) note_write(i, load_words[i]);
        // Readback: ends of the loaded range, random samples, and the hold-write target.
        for (int i = 0; i < 20; i++) begin
            if (i == 0) idx = HOLD_IDX;
            else if (eff == 0) idx = known_q[$urandom_range(known_q.size() - 1)];
            else if (i == 1) idx = 0;
            else if (i == 2) idx = eff - 1;
            else idx = $urandom_range(eff - 1);
            r_en = 1; r_addr = make_addr(idx); step(); r_en = 0;
            n_vec++; if (inst !== model_mem[idx] || inst_valid !== 1'b1) begin
                n_err++; $display("FAIL load_rd idx=%0d got=%h/%b exp=%h/1",
                                  idx, inst, inst_valid, model_mem[idx]);
            end
        end
    endtask

    task automatic test_spec_load();
        load_words = {32'h0010_0513, 32'h0020_0593};
        run_load(2, 1);
        r_en = 1; r_addr = 32'h0; step();
        n_vec++; if (inst !== 32'h0010_0513) begin
            n_err++; $display("FAIL spec_w0 got=%h exp=00100513", inst);
        end
        r_addr = 32'h4; step(); r_en = 0;
        n_vec++; if (inst !== 32'h0020_0593) begin
            n_err++; $display("FAIL spec_w1 got=%h exp=00200593", inst);
        end
        load_words = {32'h1111_2222};
        run_load(1, 3);
        load_words = {32'h0010_0513};
        run_load(1, 3);
    endtask

    task automatic test_random_loads();
        int len;
        for (int k = 0; k < 6; k++) begin
            len = (k == 0) ? 0 : $urandom_range(20, 1);
            load_words = {};
            for (int i = 0; i < len; i++) load_words.push_back($urandom);
            run_load(len, $urandom_range(3, 1));
        end
    endtask

    task automatic test_overflow();
        load_words = {};
        for (int i = 0; i < DEPTH; i++) load_words.push_back($urandom);
        run_load(DEPTH + 1, 1);
        load_words = {$urandom};
        run_load(1, 1);
    endtask

    task automatic test_reset_abort();
        logic [31:0] w0, w1, w1_old, w;
        w0 = $urandom; w1 = $urandom; w1_old = model_mem[1];
        load_words = {w0, w1};
        load_start = 1; load_len = 13'd2; step(); load_start = 0;
        for (int bi = 0; bi < 6; bi++) begin
            w = load_words[bi / 4];
            byte_valid = 1; byte_data = w[8 * (bi % 4) +: 8];
            step();
        end
        byte_valid = 0; rst = 1; step(); rst = 0;
        n_vec++; if (inst !== NOP || {inst_valid, hold, byte_ready, load_done, load_err} !== 5'b0)
        begin
            n_err++; $display("FAIL abort_reset got=%h/%b exp=%h/00000", inst,
                              {inst_valid, hold, byte_ready, load_done, load_err}, NOP);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (load_done !== 1'b0 || hold !== 1'b0) begin
                n_err++; $display("FAIL abort_idle got=%b%b exp=00", load_done, hold);
            end
        end
        model_mem[0] = w0;
        r_en = 1; r_addr = make_addr(0); step();
        n_vec++; if (inst !== w0) begin n_err++; $display("FAIL abort_w0 got=%h exp=%h", inst, w0); end
        r_addr = make_addr(1); step(); r_en = 0;
        n_vec++; if (inst !== w1_old) begin
            n_err++; $display("FAIL abort_w1 got=%h exp=%h", inst, w1_old);
        end
        // Reset wins over a simultaneous start.
        rst = 1; load_start = 1; load_len = 13'd5; step(); rst = 0; load_start = 0;
        n_vec++; if ({hold, byte_ready} !== 2'b00) begin
            n_err++; $display("FAIL rst_vs_start got=%b exp=00", {hold, byte_ready});
        end
        step();
        n_vec++; if ({hold, byte_ready, load_done} !== 3'b000) begin
            n_err++; $display("FAIL rst_vs_start2 got=%b exp=000", {hold, byte_ready, load_done});
        end
    endtask

    initial begin
        test_reset();
        test_direct_rw();
        test_forward();
        test_spec_load();
        test_random_loads();
        test_overflow();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
